// File: rtl/wb_burst_reader_if.sv
// Bundle of the command port, Wishbone B3 master bus, output stream and status
// for wb_burst_reader; master is the reader's view, slave is the environment's.
interface wb_burst_reader_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [aw-1:0] cmd_adr_i;
    logic [15:0]   cmd_len_i;

    logic [aw-1:0] wbm_adr_o;
    logic [dw-1:0] wbm_dat_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_we_o;
    logic [1:0]    wbm_bte_o;
    logic [2:0]    wbm_cti_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic [dw-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;
    logic          wbm_rty_i;

    logic [dw-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;

    logic          busy_o;
    logic          done_o;
    logic          err_o;

    modport master (
        input  cmd_valid_i, cmd_adr_i, cmd_len_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  m_ready_i,
        output cmd_ready_o,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_bte_o, wbm_cti_o,
        output wbm_cyc_o, wbm_stb_o,
        output m_data_o, m_valid_o,
        output busy_o, done_o, err_o
    );

    modport slave (
        output cmd_valid_i, cmd_adr_i, cmd_len_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output m_ready_i,
        input  cmd_ready_o,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_bte_o, wbm_cti_o,
        input  wbm_cyc_o, wbm_stb_o,
        input  m_data_o, m_valid_o,
        input  busy_o, done_o, err_o
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone B3 burst-read master: splits a (adr, len) command into linear
// incrementing bursts and streams the returned words out through a FWFT FIFO.
// Handshakes: a command transfers on cmd_valid_i & cmd_ready_o, a stream word on
// m_valid_o & m_ready_i, a bus beat on wbm_stb_o & (wbm_ack_i | wbm_err_i | wbm_rty_i).
module wb_burst_reader #(
    parameter int aw         = 32,
    parameter int dw         = 32,
    parameter int max_burst  = 16,
    parameter int fifo_depth = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_burst_reader_if.master bus,
    output logic [1:0]        dbg_state
);
    localparam int cw = $clog2(fifo_depth);
    localparam int bw = $clog2(max_burst) + 1;

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_wait  = 2'd1;
    localparam logic [1:0] st_burst = 2'd2;
    localparam logic [1:0] st_gap   = 2'd3;

    logic [1:0]    state;
    logic [aw-1:0] adr;
    logic [15:0]   rem;
    logic [bw-1:0] beats;
    logic [2:0]    cti;
    logic          cyc;
    logic          cmd_ready;
    logic          done;
    logic          err;

    logic [dw-1:0] mem [fifo_depth];
    logic [cw:0]   wr_ptr;
    logic [cw:0]   rd_ptr;
    logic [cw:0]   count;
    logic [cw:0]   free;
    logic          valid;

    logic [15:0]   blen;
    logic          accept;
    logic          bus_fault;
    logic          push;
    logic          pop;

    assign count     = wr_ptr - rd_ptr;
    assign free      = (cw + 1)'(fifo_depth) - count;
    assign valid     = (count != '0) && !wb_rst_i;
    assign blen      = (rem < 16'(max_burst)) ? rem : 16'(max_burst);
    assign accept    = bus.cmd_valid_i && cmd_ready;
    assign bus_fault = cyc && (bus.wbm_err_i || bus.wbm_rty_i);
    assign push      = cyc && bus.wbm_ack_i && !bus_fault;
    assign pop       = valid && bus.m_ready_i;

    // Reset masks the bus strobes and handshakes in the very cycle it is raised.
    assign bus.wbm_cyc_o   = cyc && !wb_rst_i;
    assign bus.wbm_stb_o   = cyc && !wb_rst_i;
    assign bus.cmd_ready_o = cmd_ready && !wb_rst_i;
    assign bus.m_valid_o   = valid;
    assign bus.m_data_o    = mem[rd_ptr[cw-1:0]];
    assign bus.wbm_adr_o   = adr;
    assign bus.wbm_cti_o   = cti;
    assign bus.wbm_dat_o   = '0;
    assign bus.wbm_sel_o   = 4'hf;
    assign bus.wbm_we_o    = 1'b0;
    assign bus.wbm_bte_o   = 2'b00;
    assign bus.busy_o      = (state != st_idle);
    assign bus.done_o      = done;
    assign bus.err_o       = err;
    assign dbg_state       = state;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= st_idle;
            adr       <= '0;
            rem       <= '0;
            beats     <= '0;
            cti       <= 3'b000;
            cyc       <= 1'b0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        adr <= bus.cmd_adr_i;
                        rem <= bus.cmd_len_i;
                        err <= 1'b0;
                        if (bus.cmd_len_i == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= st_wait;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                st_wait: begin
                    // Only start once the whole burst fits, so acks never meet a full FIFO.
                    if (16'(free) >= blen) begin
                        state <= st_burst;
                        cyc   <= 1'b1;
                        beats <= bw'(blen);
                        cti   <= (blen == 16'd1) ? 3'b000 : 3'b010;
                    end
                end
                st_burst: begin
                    if (bus_fault) begin
                        state     <= st_idle;
                        cyc       <= 1'b0;
                        cti       <= 3'b000;
                        rem       <= '0;
                        beats     <= '0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else if (bus.wbm_ack_i) begin
                        adr   <= adr + aw'(1);
                        rem   <= rem - 16'd1;
                        beats <= beats - bw'(1);
                        if (beats == bw'(1)) begin
                            state <= st_gap;
                            cyc   <= 1'b0;
                            cti   <= 3'b000;
                        end else if (beats == bw'(2)) begin
                            cti <= 3'b111;
                        end
                    end
                end
                default: begin
                    if (rem != 16'd0) begin
                        state <= st_wait;
                    end else begin
                        state     <= st_idle;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (cw + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (cw + 1)'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) mem[wr_ptr[cw-1:0]] <= bus.wbm_dat_i;
    end
endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: a word-addressed memory slave, a stream sink and a
// queue-based reference model of the burst split and returned data.
`timescale 1ns/1ps
module tb_wb_burst_reader;
    localparam int aw         = 32;
    localparam int dw         = 32;
    localparam int max_burst  = 16;
    localparam int fifo_depth = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    wb_burst_reader_if #(.aw(aw), .dw(dw)) bus ();

    wb_burst_reader #(
        .aw(aw), .dw(dw), .max_burst(max_burst), .fifo_depth(fifo_depth)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [dw-1:0]   exp_q[$];
    logic [aw+2:0]   beat_q[$];
    int pass_cnt = 0;
    int chk_cnt = 0;
    int beats_cnt = 0;
    int done_cnt = 0;
    int bursts_cnt = 0;
    int cyc_cnt = 0;
    int exp_bursts = 0;
    int fault_beat = 0;
    bit fault_rty = 1'b0;
    int sink_mode = 0;
    int drain_budget = 0;
    bit stall_mode = 1'b0;
    bit err_check_pending = 1'b0;
    logic cyc_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        chk_cnt++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return a * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    // Reference model: words expected on the stream and (cti, adr) of every bus beat.
    task automatic model_cmd(input logic [31:0] adr, input int len, input int fbeat);
        int nbeats;
        int nwords;
        int k;
        int b;
        logic [2:0] c;
        nbeats = (fbeat != 0 && fbeat <= len) ? fbeat : len;
        nwords = (fbeat != 0 && fbeat <= len) ? fbeat - 1 : len;
        for (int i = 0; i < nwords; i++) exp_q.push_back(mem_word(adr + 32'(i)));
        exp_bursts = 0;
        k = 0;
        while (k < nbeats) begin
            b = (len - k < max_burst) ? len - k : max_burst;
            exp_bursts++;
            for (int j = 0; j < b && k < nbeats; j++) begin
                c = (b == 1) ? 3'b000 : ((j == b - 1) ? 3'b111 : 3'b010);
                beat_q.push_back({c, adr + 32'(k)});
                k++;
            end
        end
    endtask

    // Slave, sink and monitor: all decisions taken on the falling edge.
    initial begin
        logic          rdy;
        logic [dw-1:0] e;
        logic [aw+2:0] bt;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_rty_i = 1'b0;
        bus.wbm_dat_i = '0;
        bus.m_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            case (sink_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = (drain_budget > 0);
            endcase
            bus.m_ready_i = rdy;
            if (!rst && bus.m_valid_o && rdy) begin
                if (sink_mode == 2) drain_budget--;
                if (exp_q.size() == 0) fail("stream_extra");
                else begin
                    e = exp_q.pop_front();
                    check("stream_data", bus.m_data_o, e);
                end
            end
            if (!rst) begin
                if (bus.wbm_cyc_o && !cyc_prev) bursts_cnt++;
                if (bus.wbm_cyc_o) cyc_cnt++;
                if (err_check_pending) begin
                    err_check_pending = 1'b0;
                    check("err_cyc_drop", bus.wbm_cyc_o, 0);
                    check("err_sticky", bus.err_o, 1);
                    check("err_done", bus.done_o, 1);
                end
                if (bus.done_o) begin
                    done_cnt++;
                    check("done_cmd_ready", bus.cmd_ready_o, 1);
                end
            end
            cyc_prev = bus.wbm_cyc_o;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_rty_i = 1'b0;
            if (!rst && bus.wbm_cyc_o && bus.wbm_stb_o && (!stall_mode || $urandom_range(0, 2) != 0)) begin
                beats_cnt++;
                if (beat_q.size() == 0) fail("beat_extra");
                else begin
                    bt = beat_q.pop_front();
                    check("beat_adr", bus.wbm_adr_o, bt[aw-1:0]);
                    check("beat_cti", bus.wbm_cti_o, bt[aw+2:aw]);
                end
                if (beats_cnt == fault_beat) begin
                    if (fault_rty) bus.wbm_rty_i = 1'b1;
                    else bus.wbm_err_i = 1'b1;
                    err_check_pending = 1'b1;
                end else begin
                    bus.wbm_ack_i = 1'b1;
                    bus.wbm_dat_i = mem_word(bus.wbm_adr_o);
                end
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] adr, input int len, input int fbeat, input bit rty);
        bit was_empty;
        int n;
        was_empty = (exp_q.size() == 0) && !bus.m_valid_o;
        model_cmd(adr, len, fbeat);
        beats_cnt = 0;
        done_cnt = 0;
        bursts_cnt = 0;
        cyc_cnt = 0;
        fault_beat = fbeat;
        fault_rty = rty;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_adr_i = adr;
        bus.cmd_len_i = 16'(len);
        n = 0;
        while (!bus.cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready_o) begin
            fail("cmd_accept_timeout");
            bus.cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        check("err_cleared", bus.err_o, 0);
        if (len == 0) begin
            check("zero_done", bus.done_o, 1);
            check("zero_busy", bus.busy_o, 0);
        end else begin
            check("busy_after_accept", bus.busy_o, 1);
            check("stb_after_accept", bus.wbm_stb_o, 0);
            if (was_empty) begin
                @(posedge clk);
                #1;
                check("first_stb", bus.wbm_stb_o, 1);
            end
        end
    endtask

    task automatic finish_cmd(input bit exp_err);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) fail("done_timeout");
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("burst_count", bursts_cnt, exp_bursts);
        check("beats_left", beat_q.size(), 0);
        check("words_left", exp_q.size(), 0);
        check("err_final", bus.err_o, exp_err);
        check("busy_final", bus.busy_o, 0);
        check("stream_drained", bus.m_valid_o, 0);
        exp_q.delete();
        beat_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int fb;
        logic [31:0] a;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_adr_i = '0;
        bus.cmd_len_i = '0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready_o, 0);
        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_stb", bus.wbm_stb_o, 0);
        check("rst_cti", bus.wbm_cti_o, 0);
        check("rst_adr", bus.wbm_adr_o, 0);
        check("rst_m_valid", bus.m_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_err", bus.err_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_ready_after_rst", bus.cmd_ready_o, 1);

        // Single classic read, split burst, error, zero length.
        issue_cmd(32'h10, 1, 0, 1'b0);
        finish_cmd(1'b0);
        issue_cmd(32'h100, 20, 0, 1'b0);
        finish_cmd(1'b0);
        issue_cmd(32'h300, 8, 3, 1'b0);
        finish_cmd(1'b1);
        issue_cmd(32'h0, 0, 0, 1'b0);
        finish_cmd(1'b0);
        check("zero_no_cyc", cyc_cnt, 0);

        // Backpressure: 32 words fill the FIFO, the last 8-beat burst needs 8 free slots.
        sink_mode = 2;
        drain_budget = 0;
        issue_cmd(32'h4000, 40, 0, 1'b0);
        n = 0;
        while (beats_cnt < 32 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("bp_beats_held", beats_cnt, 32);
        check("bp_state_wait", dbg_state, 2'd1);
        check("bp_valid", bus.m_valid_o, 1);
        drain_budget = 7;
        repeat (30) @(negedge clk);
        check("bp_still_held", beats_cnt, 32);
        drain_budget = drain_budget + 1;
        n = 0;
        while (beats_cnt < 40 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_final_burst", beats_cnt, 40);
        sink_mode = 0;
        finish_cmd(1'b0);

        // Reset in the middle of a 16-beat burst.
        issue_cmd(32'h200, 16, 0, 1'b0);
        n = 0;
        while (beats_cnt < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        check("midrst_cyc", bus.wbm_cyc_o, 0);
        check("midrst_stb", bus.wbm_stb_o, 0);
        check("midrst_m_valid", bus.m_valid_o, 0);
        @(posedge clk);
        #1;
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_cti", bus.wbm_cti_o, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        beat_q.delete();
        err_check_pending = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_cmd_ready", bus.cmd_ready_o, 1);
        check("midrst_fifo_empty", bus.m_valid_o, 0);
        issue_cmd(32'h200, 5, 0, 1'b0);
        finish_cmd(1'b0);

        // Randomized commands, including address wrap, wait states, err/rty and sink stalls.
        for (int t = 0; t < 25; t++) begin
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            len = $urandom_range(0, 40);
            fb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 2) : 0;
            sink_mode = $urandom_range(0, 1);
            stall_mode = 1'($urandom_range(0, 1));
            issue_cmd(a, len, fb, 1'($urandom_range(0, 1)));
            finish_cmd(fb != 0 && fb <= len);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
